// File: rtl/axi_pkt_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_if : AXI-Stream bundle (tvalid/tready/tdata/tlast/tuser).
//
// Parameters
//   DATA_W : tdata width
//   USER_W : tuser width
//
// Modports
//   master : drives tvalid/tdata/tlast/tuser, receives tready
//   slave  : receives tvalid/tdata/tlast/tuser, drives tready
// -----------------------------------------------------------------------------
interface axi_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 8
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axi_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// axi_pkt_arbiter : packet-level round-robin arbiter that shares one
// AXI-Stream sink between NUM_SRC upstream sources. The grant is held from the
// first beat up to and including the tlast beat, so packets never interleave.
// The output is a single registered pipeline stage.
//
// Parameters
//   DATA_W  : tdata width
//   USER_W  : tuser width
//   NUM_SRC : number of sources (2..16)
//
// Ports
//   clk       : single clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   s_tvalid  : per-source valid                  [NUM_SRC]
//   s_tready  : per-source ready (owner only)     [NUM_SRC]
//   s_tdata   : source i at [i*DATA_W +: DATA_W]
//   s_tlast   : per-source last                   [NUM_SRC]
//   s_tuser   : source i at [i*USER_W +: USER_W]
//   m_axi_if  : axi_if.master toward the sink
//   grant     : one-hot current owner, 0 when idle
//   busy      : high while a packet owns the sink
//
// Configuration macro
//   AXI_PKT_ARB_SRC_TAG_EN : when defined, m_tuser[SRC_W-1:0] carries the
//                            owner index on every beat (needs USER_W >= SRC_W);
//                            when undefined, tuser passes through unmodified.
// -----------------------------------------------------------------------------
module axi_pkt_arbiter #(
  parameter int DATA_W  = 32,
  parameter int USER_W  = 8,
  parameter int NUM_SRC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tlast,
  input  logic [NUM_SRC*USER_W-1:0] s_tuser,
  axi_if.master                     m_axi_if,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy
);

  localparam int SRC_W = $clog2(NUM_SRC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [SRC_W-1:0]    r_rr_ptr;
  logic [SRC_W-1:0]    r_gnt_idx;
  logic [NUM_SRC-1:0]  r_grant;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic [USER_W-1:0]   r_out_user;

  logic [SRC_W-1:0]    w_win_idx;
  logic                w_win_found;
  logic [SRC_W-1:0]    w_ptr_after;

  logic                w_owner_valid;
  logic                w_owner_last;
  logic [DATA_W-1:0]   w_owner_data;
  logic [USER_W-1:0]   w_owner_user;
  logic [USER_W-1:0]   w_beat_user;

  logic                w_owner_ready;
  logic                w_busy;
  logic [NUM_SRC-1:0]  w_tready;
  logic                w_push;
  logic                w_pop;
  logic                w_pkt_end;

  // Owner's beat fields, selected by the registered grant index
  assign w_owner_valid = s_tvalid[r_gnt_idx];
  assign w_owner_last  = s_tlast[r_gnt_idx];
  assign w_owner_data  = s_tdata[int'(r_gnt_idx)*DATA_W +: DATA_W];
  assign w_owner_user  = s_tuser[int'(r_gnt_idx)*USER_W +: USER_W];

  // The owner may push when the output slot is empty or drains this cycle;
  // this is the combinational path from m_tready to s_tready.
  assign w_owner_ready = !r_out_valid || m_axi_if.tready;
  assign w_push        = w_busy && w_owner_valid && w_owner_ready;
  assign w_pop         = r_out_valid && m_axi_if.tready;
  assign w_pkt_end     = w_push && w_owner_last;

  // Next round-robin pointer with an explicit wrap, valid for any NUM_SRC
  assign w_ptr_after = (r_gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : (r_gnt_idx + SRC_W'(1));

  // Round-robin winner: first valid source scanning upward from r_rr_ptr
  always_comb begin
    int               v_raw;
    logic [SRC_W-1:0] v_cand;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      v_raw  = int'(r_rr_ptr) + k;
      v_cand = (v_raw >= NUM_SRC) ? SRC_W'(v_raw - NUM_SRC) : SRC_W'(v_raw);
      if (!w_win_found && s_tvalid[v_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = v_cand;
      end else begin
        w_win_idx   = w_win_idx;
      end
    end
  end

  // Optional source tagging of the low tuser bits
`ifdef AXI_PKT_ARB_SRC_TAG_EN
  if (USER_W < SRC_W) begin : g_user_w_check
    $error("axi_pkt_arbiter: USER_W must be >= SRC_W when source tagging is enabled");
  end

  // Overlay the owner index onto the low tuser bits
  always_comb begin
    w_beat_user              = w_owner_user;
    w_beat_user[SRC_W-1:0]   = r_gnt_idx;
  end
`else
  assign w_beat_user = w_owner_user;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: grant on any request, release on the tlast push
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_win_found) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_pkt_end) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and per-source ready (only the owner can be ready)
  always_comb begin
    w_busy   = 1'b0;
    w_tready = '0;
    case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_tready = '0;
      end
      ST_BUSY: begin
        w_busy = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (r_gnt_idx == SRC_W'(i)) begin
            w_tready[i] = w_owner_ready;
          end else begin
            w_tready[i] = 1'b0;
          end
        end
      end
      default: begin
        w_busy   = 1'b0;
        w_tready = '0;
      end
    endcase
  end

  // Grant bookkeeping: capture winner on grant, advance pointer on packet end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_grant   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_gnt_idx <= w_win_idx;
            r_grant   <= {{(NUM_SRC-1){1'b0}}, 1'b1} << w_win_idx;
          end else begin
            r_grant   <= '0;
          end
        end
        ST_BUSY: begin
          if (w_pkt_end) begin
            r_rr_ptr <= w_ptr_after;
            r_grant  <= '0;
          end else begin
            r_grant  <= r_grant;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

  // Output pipeline stage; a push in the same cycle as a pop keeps it full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_user  <= '0;
    end else begin
      if (w_push) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_owner_data;
        r_out_last  <= w_owner_last;
        r_out_user  <= w_beat_user;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign s_tready        = w_tready;
  assign grant           = r_grant;
  assign busy            = w_busy;

  assign m_axi_if.tvalid = r_out_valid;
  assign m_axi_if.tdata  = r_out_data;
  assign m_axi_if.tlast  = r_out_last;
  assign m_axi_if.tuser  = r_out_user;

endmodule
